data_memory_lanes: RTL
======================

# data_memory_lanes

Byte-addressable data memory for the MEM stage of the pipelined MIPS core. It supports byte, halfword and word loads/stores with sign or zero extension, selectable endianness, misalignment detection and a configurable read latency. A debug dump port streams the whole memory byte-by-byte to the debug unit over a valid/ready handshake, independent of pipeline stalls.

## Interface
- MEMORY_WIDTH, 8: bits per memory entry; fixed at 8.
- MEMORY_DEPTH, 128: entries (bytes); must equal 2**NB_ADDR and be a multiple of 4.
- NB_ADDR, 7: byte address width.
- NB_DATA, 32: pipeline data width.
- BIG_ENDIAN, 1: 1 = byte at address A is the MSB of the word; 0 = byte at A is the LSB.
- READ_LATENCY, 1: 1 or 2 cycles from request edge to o_read_data.

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  pipeline enable; 0 = stall.
- i_mem_write_flag  in  1  store request.
- i_mem_read_flag  in  1  load request.
- i_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- i_signed  in  1  1 = sign-extend byte/half loads; 0 = zero-extend.
- i_address  in  NB_ADDR  byte address.
- i_write_data  in  NB_DATA  store data, right-aligned.
- o_read_data  out  NB_DATA  load result.
- o_read_valid  out  1  o_read_data holds a new load result.
- o_misaligned  out  1  misaligned-access flag, aligned with read timing.
- i_dump_start  in  1  start a full-memory dump.
- i_dump_ready  in  1  debug unit accepts o_dump_byte.
- o_dump_byte  out  8  dumped byte.
- o_dump_valid  out  1  o_dump_byte valid.
- o_dump_last  out  1  current byte is address MEMORY_DEPTH-1.
- o_dump_busy  out  1  dump in progress.

## Operation
- Alignment: a halfword needs address[0]=0; a word needs address[1:0]=00. On a misaligned access:
  - no memory write occurs;
  - a load returns 0;
  - o_misaligned=1 in the same cycle o_read_valid would rise (a store also raises it, one pulse).
- Store, aligned, i_enable=1:
  - writes the low 1, 2 or 4 bytes of i_write_data at address..address+size-1;
  - ordering follows BIG_ENDIAN.
- Load, aligned:
  - gathers the same bytes in BIG_ENDIAN order;
  - byte/half results are extended to NB_DATA per i_signed.
- Write and read flags both set: the write is performed; the read returns pre-write contents (read-first).
- Memory contents initialise to zero at configuration. Reset does not clear them.
- Dump FSM states:
  - IDLE: i_dump_start=1 -> FETCH, pointer=0, busy=1. i_dump_start is ignored while busy.
  - FETCH: register the byte at the pointer into o_dump_byte; set valid=1 and last=(pointer==MEMORY_DEPTH-1) -> PRESENT.
  - PRESENT: hold all outputs until i_dump_ready=1. Then:
    - if last: valid=0, last=0, busy=0 -> IDLE;
    - else: pointer+1, valid=0 -> FETCH.
- The dump ignores i_enable. Pipeline stores during a dump proceed; a dumped byte reflects memory at its FETCH cycle.

## Timing
- Reset values: o_read_data=0, o_read_valid=0, o_misaligned=0, o_dump_byte=0, o_dump_valid=0, o_dump_last=0, o_dump_busy=0; FSM=IDLE; pointer=0.
- Stores commit at the rising edge where the request is sampled.
- Read latency, request sampled at edge N:
  - READ_LATENCY=1: o_read_data and o_read_valid are valid after edge N, for one cycle;
  - READ_LATENCY=2: they are valid after edge N+1.
- o_read_valid pulses once per sampled read.
- i_enable=0: no sample, no write; all read-pipeline registers (data, valid, misaligned) hold.
- Dump throughput is one byte per 2 cycles at ready=1: FETCH, then PRESENT.
- A full dump takes 2*MEMORY_DEPTH cycles minimum from the first FETCH.
- Reset asserted mid-dump: immediate return to IDLE with all dump outputs 0. The next dump restarts at address 0.

## Test plan
- BIG_ENDIAN=1, READ_LATENCY=1:
  - SW 0xDEADBEEF @0x10, then LW @0x10 -> 0xDEADBEEF one cycle after the request;
  - LB signed @0x10 -> 0xFFFFFFDE;
  - LBU @0x11 -> 0x000000AD;
  - LH signed @0x12 -> 0xFFFFBEEF;
  - LHU @0x12 -> 0x0000BEEF.
- BIG_ENDIAN=0:
  - SW 0x11223344 @0x20, then LB @0x20 -> 0x00000044;
  - LH @0x22 -> 0x00001122.
- SW 0xCAFEF00D @0x21 (misaligned):
  - o_misaligned pulses for 1 cycle;
  - LW @0x20 is unchanged;
  - LH @0x23 returns 0 with o_misaligned=1.
- READ_LATENCY=2:
  - LW @0x10 -> data and valid 2 cycles after the request;
  - i_enable=0 for 3 cycles mid-pipeline -> outputs hold, then resume with no lost or duplicated valid.
- Dump of a memory filled with data=address (0x00..0x7F), i_dump_ready toggling 1010...:
  - 128 bytes in order 0x00..0x7F;
  - o_dump_last only on 0x7F;
  - busy drops after the final accept.
- Reset asserted during the dump at byte 0x40:
  - all outputs go to 0 asynchronously;
  - a new i_dump_start delivers 0x00 first.

Source files
------------

// File: rtl/data_memory_lanes.sv
`default_nettype none
//============================================================================
// Module   : data_memory_lanes
// Brief    : Byte-addressable MEM-stage data memory. Byte/half/word loads
//            and stores with sign/zero extension, selectable endianness,
//            misalignment detection, 1- or 2-cycle read latency, and a
//            valid/ready debug dump port streaming every byte in order.
// Revision : 1.0 - initial release
//============================================================================
module data_memory_lanes #(
  parameter int MEMORY_WIDTH = 8,
  parameter int MEMORY_DEPTH = 128,
  parameter int NB_ADDR      = 7,
  parameter int NB_DATA      = 32,
  parameter bit BIG_ENDIAN   = 1'b1,
  parameter int READ_LATENCY = 1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_mem_write_flag,
  input  logic               i_mem_read_flag,
  input  logic [1:0]         i_size,
  input  logic               i_signed,
  input  logic [NB_ADDR-1:0] i_address,
  input  logic [NB_DATA-1:0] i_write_data,
  output logic [NB_DATA-1:0] o_read_data,
  output logic               o_read_valid,
  output logic               o_misaligned,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic [7:0]         o_dump_byte,
  output logic               o_dump_valid,
  output logic               o_dump_last,
  output logic               o_dump_busy
);

  typedef enum logic [1:0] {
    DUMP_IDLE    = 2'd0,
    DUMP_FETCH   = 2'd1,
    DUMP_PRESENT = 2'd2
  } dump_state_t;

  // Storage is not touched by reset; contents come up zero from configuration.
  logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [NB_ADDR-1:0] addr1;
  logic [NB_ADDR-1:0] addr2;
  logic [NB_ADDR-1:0] addr3;
  logic [7:0]         byte0;
  logic [7:0]         byte1;
  logic [7:0]         byte2;
  logic [7:0]         byte3;
  logic               misaligned;
  logic               write_en;
  logic [15:0]        half_value;
  logic [31:0]        word_value;
  logic [NB_DATA-1:0] load_value;

  logic [NB_DATA-1:0] s1_data;
  logic               s1_valid;
  logic               s1_mis;

  dump_state_t        state;
  dump_state_t        state_next;
  logic [NB_ADDR-1:0] ptr;
  logic [NB_ADDR-1:0] ptr_next;
  logic [7:0]         dump_byte_next;
  logic               dump_valid_next;
  logic               dump_last_next;
  logic               dump_busy_next;

  // Consecutive byte addresses of the access; aligned accesses never wrap
  // because the depth is a multiple of four.
  assign addr1 = i_address + NB_ADDR'(1);
  assign addr2 = i_address + NB_ADDR'(2);
  assign addr3 = i_address + NB_ADDR'(3);
  assign byte0 = mem[i_address];
  assign byte1 = mem[addr1];
  assign byte2 = mem[addr2];
  assign byte3 = mem[addr3];

  // Halfwords need bit 0 clear; words (size 10 or 11) need bits 1:0 clear.
  assign misaligned = ((i_size == 2'b01) && i_address[0]) ||
                      (i_size[1] && (i_address[1:0] != 2'b00));
  assign write_en   = i_enable && i_mem_write_flag && !misaligned;

  // Gather the addressed bytes in memory order and extend to pipeline width.
  always_comb begin
    half_value = BIG_ENDIAN ? {byte0, byte1} : {byte1, byte0};
    word_value = BIG_ENDIAN ? {byte0, byte1, byte2, byte3}
                            : {byte3, byte2, byte1, byte0};
    load_value = '0;
    case (i_size)
      2'b00:   load_value = i_signed ? NB_DATA'($signed(byte0)) : NB_DATA'(byte0);
      2'b01:   load_value = i_signed ? NB_DATA'($signed(half_value)) : NB_DATA'(half_value);
      default: load_value = NB_DATA'(word_value);
    endcase
  end

  // Store lanes: right-aligned store data scattered over 1, 2 or 4 bytes.
  always_ff @(posedge i_clock) begin
    if (write_en) begin
      case (i_size)
        2'b00: begin
          mem[i_address] <= i_write_data[7:0];
        end
        2'b01: begin
          if (BIG_ENDIAN) begin
            mem[i_address] <= i_write_data[15:8];
            mem[addr1]     <= i_write_data[7:0];
          end else begin
            mem[i_address] <= i_write_data[7:0];
            mem[addr1]     <= i_write_data[15:8];
          end
        end
        default: begin
          if (BIG_ENDIAN) begin
            mem[i_address] <= i_write_data[31:24];
            mem[addr1]     <= i_write_data[23:16];
            mem[addr2]     <= i_write_data[15:8];
            mem[addr3]     <= i_write_data[7:0];
          end else begin
            mem[i_address] <= i_write_data[7:0];
            mem[addr1]     <= i_write_data[15:8];
            mem[addr2]     <= i_write_data[23:16];
            mem[addr3]     <= i_write_data[31:24];
          end
        end
      endcase
    end
  end

  // First read stage: samples the request (read-first against a same-edge
  // store); data keeps the last load result when no read is sampled.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_mis   <= 1'b0;
    end else if (i_enable) begin
      s1_valid <= i_mem_read_flag;
      s1_mis   <= (i_mem_read_flag || i_mem_write_flag) && misaligned;
      if (i_mem_read_flag) begin
        s1_data <= misaligned ? '0 : load_value;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_latency_two
      logic [NB_DATA-1:0] s2_data;
      logic               s2_valid;
      logic               s2_mis;

      // Second read stage: one extra register, frozen by stalls like stage one.
      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
          s2_mis   <= 1'b0;
        end else if (i_enable) begin
          s2_data  <= s1_data;
          s2_valid <= s1_valid;
          s2_mis   <= s1_mis;
        end
      end

      assign o_read_data  = s2_data;
      assign o_read_valid = s2_valid;
      assign o_misaligned = s2_mis;
    end else begin : g_latency_one
      assign o_read_data  = s1_data;
      assign o_read_valid = s1_valid;
      assign o_misaligned = s1_mis;
    end
  endgenerate

  // Dump FSM state and registered handshake outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= DUMP_IDLE;
      ptr          <= '0;
      o_dump_byte  <= '0;
      o_dump_valid <= 1'b0;
      o_dump_last  <= 1'b0;
      o_dump_busy  <= 1'b0;
    end else begin
      state        <= state_next;
      ptr          <= ptr_next;
      o_dump_byte  <= dump_byte_next;
      o_dump_valid <= dump_valid_next;
      o_dump_last  <= dump_last_next;
      o_dump_busy  <= dump_busy_next;
    end
  end

  // Dump next-state: FETCH reads one byte, PRESENT waits for the accept.
  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    dump_byte_next  = o_dump_byte;
    dump_valid_next = o_dump_valid;
    dump_last_next  = o_dump_last;
    dump_busy_next  = o_dump_busy;
    case (state)
      DUMP_IDLE: begin
        if (i_dump_start) begin
          state_next     = DUMP_FETCH;
          ptr_next       = '0;
          dump_busy_next = 1'b1;
        end
      end
      DUMP_FETCH: begin
        dump_byte_next  = mem[ptr];
        dump_valid_next = 1'b1;
        dump_last_next  = (ptr == NB_ADDR'(MEMORY_DEPTH - 1));
        state_next      = DUMP_PRESENT;
      end
      DUMP_PRESENT: begin
        if (i_dump_ready) begin
          dump_valid_next = 1'b0;
          if (o_dump_last) begin
            dump_last_next = 1'b0;
            dump_busy_next = 1'b0;
            state_next     = DUMP_IDLE;
          end else begin
            ptr_next   = ptr + NB_ADDR'(1);
            state_next = DUMP_FETCH;
          end
        end
      end
      default: begin
        state_next = DUMP_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
